// File: rtl/gate_sweep_checker_if.sv
// Two-input gate block bus: registered operands out, five gate results back.
// The checker is the master, the gate block under test is the slave.
interface gate_sweep_checker_if;
  logic a_o;
  logic b_o;
  logic and_i;
  logic or_i;
  logic xor_i;
  logic nand_i;
  logic nor_i;

  modport master (
    output a_o, b_o,
    input  and_i, or_i, xor_i, nand_i, nor_i
  );

  modport slave (
    input  a_o, b_o,
    output and_i, or_i, xor_i, nand_i, nor_i
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sweeps the four {a,b} vectors through a gate block and checks the
// AND/OR/XOR/NAND/NOR results, keeping a sticky mask and saturating count.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  gate_sweep_checker_if.master gif,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       fail_mask,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       vec_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam int SW = ERR_W + 3;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_d, b_d;
  logic             busy_d, done_d, pass_d;
  logic [1:0]       vec_d;
  logic [4:0]       fm_d;
  logic [ERR_W-1:0] err_d;

  logic [4:0]       expct;
  logic [4:0]       obs;
  logic [4:0]       mism;
  logic [2:0]       pc;
  logic [SW-1:0]    sum;
  logic [ERR_W-1:0] err_sat;

  // Mismatch tally against the operands currently held on the bus
  always_comb begin
    expct = {~(gif.a_o | gif.b_o), ~(gif.a_o & gif.b_o),
             gif.a_o ^ gif.b_o, gif.a_o | gif.b_o,
             gif.a_o & gif.b_o};
    obs   = {gif.nor_i, gif.nand_i, gif.xor_i,
             gif.or_i, gif.and_i};
    mism  = obs ^ expct;
    pc    = 3'd0;
    for (int i = 0; i < 5; i++) begin
      pc = pc + {2'b00, mism[i]};
    end
    sum = SW'(err_cnt) + SW'(pc);
    if (sum > SW'(ERR_MAX)) begin
      err_sat = ERR_MAX;
    end else begin
      err_sat = sum[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = gif.a_o;
    b_d     = gif.b_o;
    vec_d   = vec_idx;
    fm_d    = fail_mask;
    err_d   = err_cnt;
    pass_d  = pass;
    unique case (state_q)
      S_IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          state_d = S_DRIVE;
          fm_d    = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          vec_d   = 2'd0;
        end
      end
      S_DRIVE: begin
        cnt_d = '0;
        if (SETTLE_CYCLES > 0) begin
          state_d = S_SETTLE;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_SETTLE: begin
        if (cnt_q == LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        fm_d  = fail_mask | mism;
        err_d = err_sat;
        if (vec_idx == 2'd3) begin
          state_d = S_DONE;
          pass_d  = (fm_d == 5'd0);
        end else begin
          vec_d   = vec_idx + 2'd1;
          a_d     = vec_d[1];
          b_d     = vec_d[0];
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_DRIVE) ||
             (state_d == S_SETTLE) ||
             (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      gif.a_o   <= 1'b0;
      gif.b_o   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_cnt   <= '0;
      vec_idx   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      gif.a_o   <= a_d;
      gif.b_o   <= b_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_mask <= fm_d;
      err_cnt   <= err_d;
      vec_idx   <= vec_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker with a faultable gate model
// and a result scoreboard; a second instance covers zero settle time.
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;
  int   mode = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [4:0] fm;
    logic [3:0] ec;
    logic       ps;
  } exp_t;

  exp_t sb[$];

  gate_sweep_checker_if gif();
  gate_sweep_checker_if gif0();

  logic       busy, done, pass;
  logic [4:0] fail_mask;
  logic [3:0] err_cnt;
  logic [1:0] vec_idx;
  logic       busy0, done0, pass0;
  logic [4:0] fail_mask0;
  logic [3:0] err_cnt0;
  logic [1:0] vec_idx0;

  // Gate block: 0 good, 1 AND stuck-0, 2 NOR stuck-1, 3 all inverted
  function automatic logic [4:0] gates(int m, logic a, logic b);
    logic [4:0] r;
    r = {~(a | b), ~(a & b), a ^ b, a | b, a & b};
    case (m)
      1: r[0] = 1'b0;
      2: r[4] = 1'b1;
      3: r = ~r;
      default: ;
    endcase
    return r;
  endfunction

  assign {gif.nor_i, gif.nand_i, gif.xor_i, gif.or_i, gif.and_i} =
    gates(mode, gif.a_o, gif.b_o);
  assign {gif0.nor_i, gif0.nand_i, gif0.xor_i, gif0.or_i, gif0.and_i} =
    gates(0, gif0.a_o, gif0.b_o);

  gate_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gif(gif),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .err_cnt(err_cnt), .vec_idx(vec_idx)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(0), .ERR_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .gif(gif0),
    .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fail_mask0), .err_cnt(err_cnt0), .vec_idx(vec_idx0)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at cycle 1 (first negedge after the sampling edge)
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string tag, int n0, int lat, bit vchk);
    int   n;
    exp_t e;
    n = n0;
    while (!done && n < 60) begin
      if (vchk) begin
        chk({tag, "_vec"}, 32'({busy, vec_idx, gif.a_o, gif.b_o}),
            32'({1'b1, 2'((n - 1) / 4), 2'((n - 1) / 4)}));
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, 32'(busy), 0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_mask"}, 32'(fail_mask), 32'(e.fm));
      chk({tag, "_cnt"}, 32'(err_cnt), 32'(e.ec));
      chk({tag, "_pass"}, 32'(pass), 32'(e.ps));
    end
  endtask

  initial begin
    int n;
    int seen;

    repeat (3) @(negedge clk);
    chk("reset", 32'({gif.a_o, gif.b_o, busy, done, pass,
                      fail_mask, err_cnt, vec_idx}), 0);
    chk("reset0", 32'({gif0.a_o, gif0.b_o, busy0, done0, pass0,
                       fail_mask0, err_cnt0, vec_idx0}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Good gate block, full vector/latency trace
    mode = 0;
    sb.push_back('{fm: 5'b00000, ec: 4'd0, ps: 1'b1});
    pulse_start();
    wait_done("t1", 1, 17, 1'b1);
    @(negedge clk);
    chk("t1_after", 32'({done, pass, gif.a_o, gif.b_o}), 32'(4'b0100));

    mode = 1;
    sb.push_back('{fm: 5'b00001, ec: 4'd1, ps: 1'b0});
    pulse_start();
    wait_done("t2", 1, 17, 1'b0);

    mode = 2;
    sb.push_back('{fm: 5'b10000, ec: 4'd3, ps: 1'b0});
    pulse_start();
    wait_done("t3", 1, 17, 1'b0);

    mode = 3;
    sb.push_back('{fm: 5'b11111, ec: 4'd15, ps: 1'b0});
    pulse_start();
    wait_done("t4", 1, 17, 1'b0);
    repeat (3) @(negedge clk);
    chk("t4_hold", 32'({pass, fail_mask, err_cnt}),
        32'({1'b0, 5'b11111, 4'd15}));

    // Start pulse while busy must be ignored
    mode = 0;
    sb.push_back('{fm: 5'b00000, ec: 4'd0, ps: 1'b1});
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5", 6, 17, 1'b0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) seen = 1;
    end
    chk("t5_ignored", seen, 0);

    // Start held high: back-to-back runs with a fresh clear
    mode = 1;
    sb.push_back('{fm: 5'b00001, ec: 4'd1, ps: 1'b0});
    sb.push_back('{fm: 5'b00000, ec: 4'd0, ps: 1'b1});
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done("t5a", 1, 17, 1'b0);
    mode = 0;
    @(negedge clk);
    chk("t5_gap", 32'({busy, done}), 0);
    @(negedge clk);
    start = 1'b0;
    chk("t5_clear", 32'({busy, pass, fail_mask, err_cnt}),
        32'({1'b1, 1'b0, 5'b0, 4'd0}));
    wait_done("t5b", 1, 17, 1'b0);

    // Asynchronous reset during vector 2 with errors accumulated
    mode = 3;
    pulse_start();
    n = 1;
    while (vec_idx != 2'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach", n, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async", 32'({gif.a_o, gif.b_o, busy, done, pass,
                         fail_mask, err_cnt, vec_idx}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    sb.push_back('{fm: 5'b00000, ec: 4'd0, ps: 1'b1});
    pulse_start();
    wait_done("t6", 1, 17, 1'b0);

    // Zero settle cycles
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 1;
    while (!done0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s0_lat", n, 9);
    chk("s0_res", 32'({pass0, fail_mask0, err_cnt0}),
        32'({1'b1, 5'b0, 4'd0}));

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
